// File: rtl/id_ex_hazard_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_stage_pkg
// Shared definitions for the ID/EX pipeline register and its load-use
// hazard detector: default widths, FSM state encoding, bubble constants and
// the WB-bypass match helper.
// ---------------------------------------------------------------------------
package id_ex_hazard_stage_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;

  // RUN: EX advances normally. HOLD: a multi-cycle M-unit owns EX.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } pipe_state_e;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;
  localparam logic [4:0]        REG_X0      = 5'd0;

  // True when the instruction retiring in WB writes the register that ID is
  // reading this cycle; x0 is hard-wired zero and never bypassed.
  function automatic logic wb_bypass_hit(input logic       wb_we,
                                         input logic [4:0] wb_rd,
                                         input logic [4:0] rs);
    return wb_we && (wb_rd != REG_X0) && (wb_rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_hazard_stage_hazard_detect.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_stage_hazard_detect
// Combinational load-use compare: a load sitting in EX whose destination is
// read by the valid instruction in ID.
// Ports:
//   ex_valid_i, ex_memread_i, ex_rd_i      : current ID/EX register contents
//   id_valid_i, id_rs1_i, id_rs2_i,
//   id_uses_rs1_i, id_uses_rs2_i           : instruction presented by ID
//   load_use_o                             : stall-and-bubble request
// ---------------------------------------------------------------------------
module id_ex_hazard_stage_hazard_detect
  import id_ex_hazard_stage_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  output logic       load_use_o
);

  logic ex_is_load;
  logic rs1_match;
  logic rs2_match;

  // A load to x0 produces nothing a consumer could wait for.
  assign ex_is_load = ex_valid_i && ex_memread_i && (ex_rd_i != REG_X0);
  assign rs1_match  = id_uses_rs1_i && (ex_rd_i == id_rs1_i);
  assign rs2_match  = id_uses_rs2_i && (ex_rd_i == id_rs2_i);
  assign load_use_o = id_valid_i && ex_is_load && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_stage
// ID/EX pipeline register with load-use bubble insertion, multi-cycle EX
// hold and branch flush. Registered ex_* fields feed the EX forwarding unit;
// stall_if freezes PC and IF/ID.
//
// Update priority each cycle: rst > flush (bubble) > ex_busy (hold) >
// load_use (bubble + stall) > capture ID (id_valid=0 captures a bubble).
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   id_*                   : decoded instruction in ID
//   wb_regwrite/wb_rd/wb_data : WB write port, bypassed into captured data
//   flush                  : taken branch/jump resolved in EX
//   ex_busy                : multi-cycle M-unit occupies EX
//   stall_if               : combinational freeze for PC and IF/ID
//   ex_*                   : registered ID/EX fields
//   dbg_state              : FSM state (RUN/HOLD) for observation
//   perf_lu_bubbles, perf_hold_cycles : saturating event counters, present
//                            only when HAZARD_PERF_EN is defined
// ---------------------------------------------------------------------------
module id_ex_hazard_stage #(
  parameter int XLEN   = id_ex_hazard_stage_pkg::XLEN,
  parameter int CTRL_W = id_ex_hazard_stage_pkg::CTRL_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                id_valid,
  input  logic [4:0]                          id_rs1,
  input  logic [4:0]                          id_rs2,
  input  logic [4:0]                          id_rd,
  input  logic                                id_uses_rs1,
  input  logic                                id_uses_rs2,
  input  logic                                id_regwrite,
  input  logic                                id_memread,
  input  logic [CTRL_W-1:0]                   id_ctrl,
  input  logic [XLEN-1:0]                     id_rs1_data,
  input  logic [XLEN-1:0]                     id_rs2_data,
  input  logic [XLEN-1:0]                     id_imm,
  input  logic                                wb_regwrite,
  input  logic [4:0]                          wb_rd,
  input  logic [XLEN-1:0]                     wb_data,
  input  logic                                flush,
  input  logic                                ex_busy,
  output logic                                stall_if,
  output logic                                ex_valid,
  output logic                                ex_regwrite,
  output logic                                ex_memread,
  output logic [4:0]                          ex_rs1,
  output logic [4:0]                          ex_rs2,
  output logic [4:0]                          ex_rd,
  output logic [CTRL_W-1:0]                   ex_ctrl,
  output logic [XLEN-1:0]                     ex_rs1_data,
  output logic [XLEN-1:0]                     ex_rs2_data,
  output logic [XLEN-1:0]                     ex_imm,
  output id_ex_hazard_stage_pkg::pipe_state_e dbg_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                         perf_lu_bubbles,
  output logic [31:0]                         perf_hold_cycles
`endif
);

  import id_ex_hazard_stage_pkg::*;

  pipe_state_e state_q, state_d;

  logic              valid_q,    valid_d;
  logic              regwrite_q, regwrite_d;
  logic              memread_q,  memread_d;
  logic [4:0]        rs1_q,      rs1_d;
  logic [4:0]        rs2_q,      rs2_d;
  logic [4:0]        rd_q,       rd_d;
  logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q,      imm_d;

  logic load_use;

  id_ex_hazard_stage_hazard_detect u_hazard_detect (
    .ex_valid_i    (valid_q),
    .ex_memread_i  (memread_q),
    .ex_rd_i       (rd_q),
    .id_valid_i    (id_valid),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .load_use_o    (load_use)
  );

  // A flush discards the ID instruction anyway, so it never needs a stall.
  assign stall_if = !flush && (ex_busy || load_use);

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (ex_busy && !flush)  state_d = ST_HOLD;
      ST_HOLD: if (!ex_busy || flush)  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Pipeline register next state
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    ctrl_d     = ctrl_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;

    if (flush || (!ex_busy && (load_use || !id_valid))) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      rs1_d      = REG_X0;
      rs2_d      = REG_X0;
      rd_d       = REG_X0;
      ctrl_d     = CTRL_W'(CTRL_BUBBLE);
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
    end else if (!ex_busy) begin
      valid_d    = 1'b1;
      regwrite_d = id_regwrite;
      memread_d  = id_memread;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      ctrl_d     = id_ctrl;
      // The register file is read before WB writes it this cycle, so the
      // retiring value must be forwarded into the captured operands.
      rs1_data_d = wb_bypass_hit(wb_regwrite, wb_rd, id_rs1) ? wb_data : id_rs1_data;
      rs2_data_d = wb_bypass_hit(wb_regwrite, wb_rd, id_rs2) ? wb_data : id_rs2_data;
      imm_d      = id_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      rs1_q      <= REG_X0;
      rs2_q      <= REG_X0;
      rd_q       <= REG_X0;
      ctrl_q     <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_regwrite = regwrite_q;
  assign ex_memread  = memread_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_ctrl     = ctrl_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_imm      = imm_q;
  assign dbg_state   = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] lu_cnt_q,   lu_cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;

  // Count only events that actually took effect: a flush overrides both.
  always_comb begin
    lu_cnt_d   = lu_cnt_q;
    hold_cnt_d = hold_cnt_q;
    if (!flush && !ex_busy && load_use && (lu_cnt_q != 32'hFFFF_FFFF))
      lu_cnt_d = lu_cnt_q + 32'd1;
    if (!flush && ex_busy && (hold_cnt_q != 32'hFFFF_FFFF))
      hold_cnt_d = hold_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      lu_cnt_q   <= lu_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign perf_lu_bubbles  = lu_cnt_q;
  assign perf_hold_cycles = hold_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
module tb_id_ex_hazard_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic        id_regwrite, id_memread;
  logic [15:0] id_ctrl;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_busy;
  logic        stall_if;
  logic        ex_valid, ex_regwrite, ex_memread;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [15:0] ex_ctrl;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm;
  id_ex_hazard_stage_pkg::pipe_state_e dbg_state;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_bubbles, perf_hold_cycles;
`endif

  int checks = 0;
  int errors = 0;

  id_ex_hazard_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_ctrl(id_ctrl),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ex_busy(ex_busy), .stall_if(stall_if),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .dbg_state(dbg_state)
`ifdef HAZARD_PERF_EN
    , .perf_lu_bubbles(perf_lu_bubbles), .perf_hold_cycles(perf_hold_cycles)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // What EX should be holding: the instruction record plus whether a
  // multi-cycle unit is occupying EX (1 = holding).
  typedef struct packed {
    logic        v, rw, mr;
    logic [4:0]  rs1, rs2, rd;
    logic [15:0] ctrl;
    logic [31:0] d1, d2, imm;
    logic        st;
  } ex_t;

  ex_t m;
  int unsigned m_lu_cnt;
  int unsigned m_hold_cnt;

  function automatic logic [130:0] dut_vec();
    return {ex_valid, ex_regwrite, ex_memread, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
            ex_rs1_data, ex_rs2_data, ex_imm, logic'(dbg_state)};
  endfunction

  // A consumer in ID must wait when EX holds a real load writing a
  // non-zero register it reads.
  function automatic logic model_lu();
    logic reads_it;
    reads_it = (id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd);
    return id_valid && m.v && m.mr && (m.rd != 5'd0) && reads_it;
  endfunction

  function automatic logic model_stall();
    if (flush) return 1'b0;
    return ex_busy || model_lu();
  endfunction

  function automatic ex_t model_next();
    ex_t n;
    n = '0;
    if (rst || flush) return n;
    if (ex_busy) begin
      n = m;
      n.st = 1'b1;
      return n;
    end
    if (model_lu() || !id_valid) return n;
    n.v = 1'b1; n.rw = id_regwrite; n.mr = id_memread;
    n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd; n.ctrl = id_ctrl;
    n.d1 = (wb_regwrite && wb_rd != 5'd0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
    n.d2 = (wb_regwrite && wb_rd != 5'd0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
    n.imm = id_imm;
    return n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_ctl();
    rst = 0; flush = 0; ex_busy = 0;
    wb_regwrite = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic u1, input logic u2,
                        input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_regwrite = rw; id_memread = mr;
    id_ctrl = 16'($urandom);
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    ex_t n;
    n = model_next();
    if (rst) begin
      m_lu_cnt = 0; m_hold_cnt = 0;
    end else if (!flush) begin
      if (ex_busy) m_hold_cnt++;
      else if (model_lu()) m_lu_cnt++;
    end
    @(posedge clk);
    m = n;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_ctl();
    set_id(1, 5'd1, 5'd2, 5'd3, 1, 1, 1, 1);
    rst = 1;
    tick();
    tick();
    rst = 0;
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL reset_state got %h exp 0", dut_vec());
    end
  endtask

  task automatic test_load_use();
    idle_ctl();
    set_id(1, 5'd1, 5'd2, 5'd5, 1, 1, 1, 1);  // lw x5
    tick();
    set_id(1, 5'd5, 5'd7, 5'd6, 1, 1, 1, 0);  // add x6,x5,x7
    #1;
    checks++;
    if (stall_if !== 1'b1 || model_stall() !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall got %b exp 1", stall_if);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || dut_vec() !== m) begin
      errors++;
      $display("FAIL lu_bubble got %h exp %h", dut_vec(), m);
    end
    #1;
    checks++;
    if (stall_if !== 1'b0) begin
      errors++;
      $display("FAIL lu_release_stall got %b exp 0", stall_if);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rs1 !== 5'd5 || ex_rd !== 5'd6 || dut_vec() !== m) begin
      errors++;
      $display("FAIL lu_consumer got %h exp %h", dut_vec(), m);
    end
  endtask

  task automatic test_non_hazard();
    idle_ctl();
    set_id(1, 5'd1, 5'd2, 5'd5, 1, 1, 1, 1);  // lw x5
    tick();
    set_id(1, 5'd0, 5'd7, 5'd6, 1, 1, 1, 0);  // add x6,x0,x7
    #1;
    checks++;
    if (stall_if !== 1'b0) begin
      errors++;
      $display("FAIL nh_rs1_x0_stall got %b exp 0", stall_if);
    end
    tick();
    checks++;
    if (ex_rd !== 5'd6 || ex_valid !== 1'b1 || dut_vec() !== m) begin
      errors++;
      $display("FAIL nh_capture got %h exp %h", dut_vec(), m);
    end
    set_id(1, 5'd3, 5'd4, 5'd0, 1, 1, 1, 1);  // lw x0
    tick();
    set_id(1, 5'd0, 5'd0, 5'd8, 1, 1, 1, 0);
    #1;
    checks++;
    if (stall_if !== 1'b0) begin
      errors++;
      $display("FAIL nh_rd_x0_stall got %b exp 0", stall_if);
    end
    tick();
  endtask

  task automatic test_wb_bypass();
    idle_ctl();
    set_id(1, 5'd1, 5'd3, 5'd4, 1, 1, 1, 0);
    id_rs2_data = 32'h0;
    wb_regwrite = 1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (ex_rs2_data !== 32'hDEAD_BEEF || dut_vec() !== m) begin
      errors++;
      $display("FAIL wb_bypass got %h exp deadbeef", ex_rs2_data);
    end
    set_id(1, 5'd1, 5'd0, 5'd4, 1, 1, 1, 0);
    id_rs2_data = 32'h0;
    wb_rd = 5'd0;
    tick();
    checks++;
    if (ex_rs2_data !== 32'h0 || dut_vec() !== m) begin
      errors++;
      $display("FAIL wb_bypass_x0 got %h exp 0", ex_rs2_data);
    end
  endtask

  task automatic test_busy_hold();
    ex_t held;
    int unsigned hold0;
    idle_ctl();
    hold0 = m_hold_cnt;
    set_id(1, 5'd10, 5'd11, 5'd9, 1, 1, 1, 0);  // div x9
    tick();
    held = m;
    held.st = 1'b1;
`ifdef HAZARD_PERF_EN
    hold0 = perf_hold_cycles;
`endif
    for (int i = 0; i < 33; i++) begin
      ex_busy = 1;
      set_id(1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 1, 1, 1, 1);
      #1;
      checks++;
      if (stall_if !== 1'b1) begin
        errors++;
        $display("FAIL busy_stall cyc %0d got %b exp 1", i, stall_if);
      end
      tick();
      checks++;
      if (dut_vec() !== held) begin
        errors++;
        $display("FAIL busy_hold cyc %0d got %h exp %h", i, dut_vec(), held);
      end
    end
    ex_busy = 0;
    set_id(1, 5'd12, 5'd13, 5'd14, 1, 1, 1, 0);
    #1;
    checks++;
    if (stall_if !== 1'b0) begin
      errors++;
      $display("FAIL busy_release_stall got %b exp 0", stall_if);
    end
    tick();
    checks++;
    if (ex_rd !== 5'd14 || dut_vec() !== m) begin
      errors++;
      $display("FAIL busy_release_capture got %h exp %h", dut_vec(), m);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (perf_hold_cycles - hold0 !== 32'd33) begin
      errors++;
      $display("FAIL perf_hold got %0d exp 33", perf_hold_cycles - hold0);
    end
`endif
  endtask

  task automatic test_flush_priority();
    int unsigned lu0;
    idle_ctl();
    set_id(1, 5'd1, 5'd2, 5'd5, 1, 1, 1, 1);  // lw x5
    tick();
    lu0 = m_lu_cnt;
`ifdef HAZARD_PERF_EN
    lu0 = perf_lu_bubbles;
`endif
    set_id(1, 5'd5, 5'd6, 5'd7, 1, 1, 1, 0);
    flush = 1;
    #1;
    checks++;
    if (stall_if !== 1'b0) begin
      errors++;
      $display("FAIL flush_lu_stall got %b exp 0", stall_if);
    end
    tick();
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL flush_lu_bubble got %h exp 0", dut_vec());
    end
    ex_busy = 1;
    #1;
    checks++;
    if (stall_if !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy_stall got %b exp 0", stall_if);
    end
    tick();
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL flush_busy_bubble got %h exp 0", dut_vec());
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (perf_lu_bubbles !== lu0) begin
      errors++;
      $display("FAIL perf_lu_flush got %0d exp %0d", perf_lu_bubbles, lu0);
    end
`endif
    idle_ctl();
  endtask

  task automatic test_rst_in_hold();
    idle_ctl();
    set_id(1, 5'd1, 5'd2, 5'd9, 1, 1, 1, 0);
    tick();
    ex_busy = 1;
    tick();
    tick();
    checks++;
    if (dbg_state !== id_ex_hazard_stage_pkg::ST_HOLD || dut_vec() !== m) begin
      errors++;
      $display("FAIL hold_state got %h exp %h", dut_vec(), m);
    end
    rst = 1;
    tick();
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL rst_in_hold got %h exp 0", dut_vec());
    end
    idle_ctl();
    set_id(1, 5'd3, 5'd4, 5'd15, 1, 1, 1, 0);
    #1;
    checks++;
    if (stall_if !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_stall got %b exp 0", stall_if);
    end
    tick();
    checks++;
    if (ex_rd !== 5'd15 || ex_valid !== 1'b1 || dut_vec() !== m) begin
      errors++;
      $display("FAIL post_rst_capture got %h exp %h", dut_vec(), m);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 99) < 2);
      flush       = ($urandom_range(0, 99) < 6);
      ex_busy     = ($urandom_range(0, 99) < 15);
      wb_regwrite = $urandom_range(0, 1);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      set_id($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 2) == 0);
      #1;
      checks++;
      if (stall_if !== model_stall()) begin
        errors++;
        $display("FAIL rand_stall cyc %0d got %b exp %b", i, stall_if, model_stall());
      end
      tick();
      checks++;
      if (dut_vec() !== m) begin
        errors++;
        $display("FAIL rand_ex cyc %0d got %h exp %h", i, dut_vec(), m);
      end
`ifdef HAZARD_PERF_EN
      checks++;
      if (perf_lu_bubbles !== 32'(m_lu_cnt) || perf_hold_cycles !== 32'(m_hold_cnt)) begin
        errors++;
        $display("FAIL rand_perf cyc %0d got %0d/%0d exp %0d/%0d", i,
                 perf_lu_bubbles, perf_hold_cycles, m_lu_cnt, m_hold_cnt);
      end
`endif
    end
    idle_ctl();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    m = '0;
    m_lu_cnt = 0;
    m_hold_cnt = 0;
    idle_ctl();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_non_hazard();
    test_wb_bypass();
    test_busy_hold();
    test_flush_priority();
    test_rst_in_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
